// File: rtl/dm_bus_if.sv
// Word-wide data-memory bus with a req/ready handshake.
interface dm_bus_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ready;
  logic [31:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    input  bus_ready, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    output bus_ready, bus_rdata
  );
endinterface

// File: rtl/dm_access_unit.sv
// Memory-stage load/store engine: one bus transaction per access, stalls the pipe until done.
// Optional misaligned-access trap enabled by defining DM_MISALIGN_TRAP_EN.
module dm_access_unit #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_write,
  input  logic        mem_read,
  input  logic [2:0]  dm_type,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        bus_err,
`ifdef DM_MISALIGN_TRAP_EN
  output logic        misalign,
`endif
  dm_bus_if.master    bus
);

  localparam int unsigned TMO_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t           state;
  logic [TMO_W-1:0] tmo_cnt;
  logic [2:0]       lat_type;
  logic [1:0]       lat_off;

  logic        req_c;
  logic        is_byte_c;
  logic        is_half_c;
  logic [3:0]  be_c;
  logic [31:0] wdata_c;
  logic [7:0]  lane_b_c;
  logic [15:0] lane_h_c;
  logic [31:0] ext_c;
`ifdef DM_MISALIGN_TRAP_EN
  logic        misalign_c;
`endif

  // Request decode: byte enables and lane-replicated store data from live inputs
  always_comb begin
    req_c     = mem_write | mem_read;
    is_byte_c = (dm_type == 3'b011) || (dm_type == 3'b100);
    is_half_c = (dm_type == 3'b001) || (dm_type == 3'b010);
    be_c      = 4'b1111;
    wdata_c   = wdata;
    if (is_byte_c) begin
      be_c    = 4'b0001 << addr[1:0];
      wdata_c = {4{wdata[7:0]}};
    end else if (is_half_c) begin
      be_c    = 4'b0011 << {addr[1], 1'b0};
      wdata_c = {2{wdata[15:0]}};
    end
`ifdef DM_MISALIGN_TRAP_EN
    misalign_c = (is_half_c && addr[0]) || (!is_byte_c && !is_half_c && (addr[1:0] != 2'b00));
`endif
  end

  // Load lane select and extension from the latched access type/offset
  always_comb begin
    case (lat_off)
      2'd0:    lane_b_c = bus.bus_rdata[7:0];
      2'd1:    lane_b_c = bus.bus_rdata[15:8];
      2'd2:    lane_b_c = bus.bus_rdata[23:16];
      default: lane_b_c = bus.bus_rdata[31:24];
    endcase
    lane_h_c = lat_off[1] ? bus.bus_rdata[31:16] : bus.bus_rdata[15:0];
    case (lat_type)
      3'b001:  ext_c = {{16{lane_h_c[15]}}, lane_h_c};
      3'b010:  ext_c = {16'h0000, lane_h_c};
      3'b011:  ext_c = {{24{lane_b_c[7]}}, lane_b_c};
      3'b100:  ext_c = {24'h000000, lane_b_c};
      default: ext_c = bus.bus_rdata;
    endcase
  end

  // The IDLE term lets the pipe freeze in the same cycle the request appears
  assign stall = !rst && (((state == IDLE) && req_c) || (state == REQ));

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      tmo_cnt       <= '0;
      lat_type      <= '0;
      lat_off       <= '0;
      rdata         <= '0;
      bus_err       <= 1'b0;
      bus.bus_req   <= 1'b0;
      bus.bus_we    <= 1'b0;
      bus.bus_addr  <= '0;
      bus.bus_be    <= '0;
      bus.bus_wdata <= '0;
`ifdef DM_MISALIGN_TRAP_EN
      misalign      <= 1'b0;
`endif
    end else begin
      bus_err <= 1'b0;
`ifdef DM_MISALIGN_TRAP_EN
      misalign <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (req_c) begin
            lat_type   <= dm_type;
            lat_off    <= addr[1:0];
            bus.bus_we <= mem_write;
            tmo_cnt    <= '0;
`ifdef DM_MISALIGN_TRAP_EN
            if (misalign_c) begin
              misalign <= 1'b1;
              state    <= DONE;
            end else
`endif
            begin
              bus.bus_req   <= 1'b1;
              bus.bus_addr  <= {addr[31:2], 2'b00};
              bus.bus_be    <= be_c;
              bus.bus_wdata <= wdata_c;
              state         <= REQ;
            end
          end
        end
        REQ: begin
          if (bus.bus_ready) begin
            if (!bus.bus_we) rdata <= ext_c;
            bus.bus_req <= 1'b0;
            state       <= DONE;
          end else if ((TIMEOUT > 0) && (tmo_cnt == TMO_LAST)) begin
            if (!bus.bus_we) rdata <= '0;
            bus_err     <= 1'b1;
            bus.bus_req <= 1'b0;
            state       <= DONE;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dm_access_unit.sv
// Directed scoreboard bench for dm_access_unit (expected rdata queued at request, popped at completion).
module tb_dm_access_unit;
  logic        clk;
  logic        rst;
  logic        mem_write;
  logic        mem_read;
  logic [2:0]  dm_type;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        stall;
  logic        bus_err;
`ifdef DM_MISALIGN_TRAP_EN
  logic        misalign;
`endif

  dm_bus_if bus ();

  dm_access_unit #(.TIMEOUT(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_write (mem_write),
    .mem_read  (mem_read),
    .dm_type   (dm_type),
    .addr      (addr),
    .wdata     (wdata),
    .rdata     (rdata),
    .stall     (stall),
    .bus_err   (bus_err),
`ifdef DM_MISALIGN_TRAP_EN
    .misalign  (misalign),
`endif
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          passed = 0;
  int          total  = 0;
  logic [31:0] exp_q[$];
  logic [31:0] rd_model;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [31:0] model_ext(input logic [2:0] typ, input logic [1:0] off,
                                            input logic [31:0] w);
    logic [31:0] s;
    s = w >> (8 * off);
    case (typ)
      3'b001:  return {{16{s[15]}}, s[15:0]};
      3'b010:  return {16'h0, s[15:0]};
      3'b011:  return {{24{s[7]}}, s[7:0]};
      3'b100:  return {24'h0, s[7:0]};
      default: return w;
    endcase
  endfunction

  task automatic access(input string tag, input logic we, input logic [2:0] typ,
                        input logic [31:0] a, input logic [31:0] wd, input logic [31:0] brd,
                        input int waits, input logic [3:0] exp_be, input logic [31:0] exp_bwd);
    int stalls;
    @(negedge clk);
    mem_write = we; mem_read = !we; dm_type = typ; addr = a; wdata = wd;
    if (!we) rd_model = model_ext(typ, a[1:0], brd);
    exp_q.push_back(rd_model);
    #1 stalls = stall ? 1 : 0;
    for (int k = 0; k <= waits; k++) begin
      @(negedge clk);
      check({tag, "_req"}, 32'(bus.bus_req), 32'd1);
      if (k == 0) begin
        check({tag, "_we"},    32'(bus.bus_we), 32'(we));
        check({tag, "_addr"},  bus.bus_addr, {a[31:2], 2'b00});
        check({tag, "_be"},    32'(bus.bus_be), 32'(exp_be));
        check({tag, "_wdata"}, bus.bus_wdata, exp_bwd);
      end
      bus.bus_ready = (k == waits);
      bus.bus_rdata = (k == waits) ? brd : ~brd;
      #1 if (stall) stalls++;
    end
    @(negedge clk);
    bus.bus_ready = 1'b0; mem_write = 1'b0; mem_read = 1'b0;
    #1;
    check({tag, "_done_stall"}, 32'(stall), 32'd0);
    check({tag, "_done_req"},   32'(bus.bus_req), 32'd0);
    check({tag, "_rdata"},      rdata, exp_q.pop_front());
    check({tag, "_stall_cyc"},  32'(stalls), 32'(waits + 2));
  endtask

  initial begin
    rst = 1'b1; mem_write = 1'b0; mem_read = 1'b0; dm_type = 3'b000;
    addr = '0; wdata = '0; bus.bus_ready = 1'b0; bus.bus_rdata = '0;
    rd_model = '0;
    repeat (3) @(negedge clk);
    check("rst_rdata", rdata, 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_err",   32'(bus_err), 32'd0);
    check("rst_req",   32'(bus.bus_req), 32'd0);
    check("rst_we",    32'(bus.bus_we), 32'd0);
    check("rst_addr",  bus.bus_addr, 32'd0);
    check("rst_be",    32'(bus.bus_be), 32'd0);
    check("rst_wdata", bus.bus_wdata, 32'd0);
    rst = 1'b0;

    access("sw",  1'b1, 3'b000, 32'h104, 32'hDEADBEEF, 32'h0,        0, 4'b1111, 32'hDEADBEEF);
    access("lb",  1'b0, 3'b011, 32'h203, 32'h0,        32'h80112233, 3, 4'b1000, 32'h0);
    check("lb_val", rdata, 32'hFFFFFF80);
    access("lhu", 1'b0, 3'b010, 32'h002, 32'h0,        32'h9ABC0000, 0, 4'b1100, 32'h0);
    check("lhu_val", rdata, 32'h00009ABC);
    access("lh",  1'b0, 3'b001, 32'h002, 32'h0,        32'h9ABC0000, 1, 4'b1100, 32'h0);
    check("lh_val", rdata, 32'hFFFF9ABC);
    access("sh",  1'b1, 3'b001, 32'h006, 32'h0000A5A5, 32'h0,        0, 4'b1100, 32'hA5A5A5A5);
    access("lbu", 1'b0, 3'b100, 32'h201, 32'h12345678, 32'h0000F700, 2, 4'b0010, 32'h78787878);
    check("lbu_val", rdata, 32'h000000F7);
    access("lw",  1'b0, 3'b000, 32'h010, 32'h0,        32'h13579BDF, 1, 4'b1111, 32'h0);

`ifdef DM_MISALIGN_TRAP_EN
    @(negedge clk);
    mem_read = 1'b1; dm_type = 3'b000; addr = 32'h101;
    #1 check("mis_stall0", 32'(stall), 32'd1);
    @(negedge clk);
    check("mis_req",   32'(bus.bus_req), 32'd0);
    check("mis_pulse", 32'(misalign), 32'd1);
    check("mis_stall", 32'(stall), 32'd0);
    check("mis_rdata", rdata, rd_model);
    mem_read = 1'b0;
    @(negedge clk);
    check("mis_clear", 32'(misalign), 32'd0);
`endif

    // Timeout: ready never arrives
    @(negedge clk);
    mem_read = 1'b1; dm_type = 3'b000; addr = 32'h40;
    rd_model = 32'd0;
    exp_q.push_back(rd_model);
    #1 check("tmo_stall0", 32'(stall), 32'd1);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      check("tmo_req", 32'(bus.bus_req), 32'd1);
    end
    @(negedge clk);
    mem_read = 1'b0;
    #1;
    check("tmo_err",   32'(bus_err), 32'd1);
    check("tmo_stall", 32'(stall), 32'd0);
    check("tmo_req_lo", 32'(bus.bus_req), 32'd0);
    check("tmo_rdata", rdata, exp_q.pop_front());
    @(negedge clk);
    check("tmo_err_pulse", 32'(bus_err), 32'd0);

    // Reset mid-REQ abandons the access
    mem_read = 1'b1; dm_type = 3'b100; addr = 32'h80;
    repeat (3) @(negedge clk);
    check("mrst_req_before", 32'(bus.bus_req), 32'd1);
    rst = 1'b1; mem_read = 1'b0; bus.bus_ready = 1'b1; bus.bus_rdata = 32'hFFFFFFFF;
    @(negedge clk);
    check("mrst_req",   32'(bus.bus_req), 32'd0);
    check("mrst_stall", 32'(stall), 32'd0);
    check("mrst_rdata", rdata, 32'd0);
    rst = 1'b0; bus.bus_ready = 1'b0;
    rd_model = 32'd0;

    access("post_lbu", 1'b0, 3'b100, 32'h3, 32'h0, 32'hC3000000, 0, 4'b1000, 32'h0);
    check("post_lbu_val", rdata, 32'h000000C3);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
